// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with column synchronizer and press/release debouncing.
// Presents the held key as one-hot row/col codes plus valid/press/release strobes.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_drive,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int DW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_MAX    = DBW'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0] deb_q, deb_d;
  logic [3:0]     col_s1_q, col_sync_q;
  logic [3:0]     row_drive_q, row_drive_d;
  logic [3:0]     cand_row_q, cand_row_d;
  logic [3:0]     cand_col_q, cand_col_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     col_q, col_d;
  logic           valid_q, valid_d;
  logic           press_q, press_d;
  logic           release_q, release_d;

  logic [3:0] row_rot;
  logic       col_onehot;
  logic       cand_hit;

  assign row_rot    = {row_drive_q[2:0], row_drive_q[3]};
  assign col_onehot = (col_sync_q != '0) && ((col_sync_q & (col_sync_q - 4'd1)) == '0);
  // Once held, only the captured column matters; other keys in the row are ignored.
  assign cand_hit   = |(col_sync_q & cand_col_q);

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    row_drive_d = row_drive_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    row_d       = row_q;
    col_d       = col_q;
    valid_d     = valid_q;
    press_d     = 1'b0;
    release_d   = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (col_onehot) begin
            cand_row_d = row_drive_q;
            cand_col_d = col_sync_q;
            deb_d      = '0;
            state_d    = DEBOUNCE;
          end else begin
            row_drive_d = row_rot;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (col_sync_q != cand_col_q) begin
          row_drive_d = row_rot;
          dwell_d     = '0;
          state_d     = SCAN;
        end else if (deb_q == DEB_MAX) begin
          row_d   = cand_row_q;
          col_d   = cand_col_q;
          valid_d = 1'b1;
          press_d = 1'b1;
          state_d = HELD;
        end else begin
          deb_d = deb_q + DBW'(1);
        end
      end
      HELD: begin
        if (!cand_hit) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (cand_hit) begin
          deb_d   = '0;
          state_d = HELD;
        end else if (deb_q == DEB_MAX) begin
          row_d       = '0;
          col_d       = '0;
          valid_d     = 1'b0;
          release_d   = 1'b1;
          row_drive_d = row_rot;
          dwell_d     = '0;
          state_d     = SCAN;
        end else begin
          deb_d = deb_q + DBW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      deb_q       <= '0;
      col_s1_q    <= '0;
      col_sync_q  <= '0;
      row_drive_q <= 4'b0001;
      cand_row_q  <= '0;
      cand_col_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      col_s1_q    <= col_in;
      col_sync_q  <= col_s1_q;
      row_drive_q <= row_drive_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      row_q       <= row_d;
      col_q       <= col_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign row_drive   = row_drive_q;
  assign row         = row_q;
  assign col         = col_q;
  assign key_valid   = valid_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in = '0;
  logic [3:0] row_drive, row, col;
  logic       key_valid, key_press, key_release;

  int n_checks = 0;
  int n_errors = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_in      (col_in),
    .row_drive   (row_drive),
    .row         (row),
    .col         (col),
    .key_valid   (key_valid),
    .key_press   (key_press),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends just after the reset is released; the next edge is "edge 1".
  task automatic do_reset();
    rst_n  = 1'b0;
    col_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Key at row 0010 / col 0100: sampled at edge 8, accepted at edge 12.
  task automatic press_to_held();
    do_reset();
    repeat (4) tick();
    col_in = 4'b0100;
    repeat (8) tick();
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] exp_rd;
    one = 4'b0001;

    // Reset state and idle scanning
    do_reset();
    check("rst_row_drive", row_drive, 4'b0001);
    check("rst_valid", key_valid, 1'b0);
    check("rst_press", key_press, 1'b0);
    check("rst_release", key_release, 1'b0);
    check("rst_rowcol", {row, col}, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_rd = one << ((i / 4) % 4);
      check("idle_row_drive", row_drive, exp_rd);
      check("idle_valid", key_valid, 1'b0);
    end
    check("idle_rowcol", {row, col}, 8'h00);

    // Clean press, then release
    do_reset();
    repeat (4) tick();
    check("pr_row_before", row_drive, 4'b0010);
    col_in = 4'b0100;
    repeat (7) tick();
    check("pr_press_early", key_press, 1'b0);
    check("pr_valid_early", key_valid, 1'b0);
    check("pr_frozen", row_drive, 4'b0010);
    tick();
    check("pr_press", key_press, 1'b1);
    check("pr_valid", key_valid, 1'b1);
    check("pr_row", row, 4'b0010);
    check("pr_col", col, 4'b0100);
    tick();
    check("pr_press_once", key_press, 1'b0);
    check("pr_valid_hold", key_valid, 1'b1);
    check("pr_drive_hold", row_drive, 4'b0010);
    col_in = '0;
    for (int e = 14; e <= 19; e++) begin
      tick();
      check("rel_early", key_release, 1'b0);
      check("rel_valid_hold", key_valid, 1'b1);
    end
    tick();
    check("rel_pulse", key_release, 1'b1);
    check("rel_valid", key_valid, 1'b0);
    check("rel_rowcol", {row, col}, 8'h00);
    check("rel_no_press", key_press, 1'b0);
    check("rel_resume", row_drive, 4'b0100);
    tick();
    check("rel_once", key_release, 1'b0);

    // Bounce on press: one-hot at edge 8, mismatch at edge 9
    do_reset();
    repeat (4) tick();
    col_in = 4'b0100;
    for (int e = 5; e <= 13; e++) begin
      tick();
      if (e >= 6 && e <= 9) col_in = (e % 2 == 0) ? 4'b0000 : 4'b0100;
      else if (e >= 10) col_in = '0;
      check("bnc_no_press", key_press, 1'b0);
      check("bnc_valid", key_valid, 1'b0);
      if (e == 8)  check("bnc_frozen", row_drive, 4'b0010);
      if (e == 9)  check("bnc_rotate", row_drive, 4'b0100);
      if (e == 13) check("bnc_next_row", row_drive, 4'b1000);
    end

    // One-cycle dropout while held
    press_to_held();
    check("gl_press", key_press, 1'b1);
    tick();
    col_in = '0;
    tick();
    col_in = 4'b0100;
    for (int e = 15; e <= 24; e++) begin
      tick();
      check("gl_no_release", key_release, 1'b0);
      check("gl_no_press", key_press, 1'b0);
      check("gl_valid", key_valid, 1'b1);
    end
    check("gl_drive", row_drive, 4'b0010);

    // Two columns at dwell end are ignored
    do_reset();
    col_in = 4'b0011;
    repeat (4) tick();
    check("two_rot1", row_drive, 4'b0010);
    repeat (4) tick();
    check("two_rot2", row_drive, 4'b0100);
    check("two_valid", key_valid, 1'b0);
    check("two_press", key_press, 1'b0);

    // Reset while held
    press_to_held();
    tick();
    check("rh_held", key_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rh_valid", key_valid, 1'b0);
    check("rh_drive", row_drive, 4'b0001);
    check("rh_press", key_press, 1'b0);
    check("rh_release", key_release, 1'b0);
    check("rh_rowcol", {row, col}, 8'h00);
    rst_n  = 1'b1;
    col_in = '0;
    tick();
    check("rh_no_release", key_release, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of KeypadDecoder: it drives the 4x4 matrix keypad rows one at a time and samples the raw column lines.
- It debounces a single key press and presents stable one-hot row/col codes to the decoder.
- It qualifies each press with level and pulse strobes.
- row/col outputs are all-zero whenever no debounced key is held, so the decoder reports valid=0.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven (dwell). Must be >= 4.
- DEBOUNCE_CNT, 20: consecutive matching cycles required to accept a press or a release. Must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- col_in  input  4  raw keypad column lines, active-high, asynchronous to clk
- row_drive  output  4  one-hot row drive to keypad matrix
- row  output  4  debounced one-hot row of held key to decoder; 0 when none
- col  output  4  debounced one-hot column of held key to decoder; 0 when none
- key_valid  output  1  high while a debounced key is held
- key_press  output  1  one-cycle pulse on press acceptance
- key_release  output  1  one-cycle pulse on release acceptance

Behaviour:
- Reset (rst_n low at clk edge), all synchronous:
  - row_drive=0001; row=0; col=0; key_valid=0; key_press=0; key_release=0.
  - State=SCAN; dwell and debounce counters=0; 2-flop col synchronizer=0.
- col_sync = col_in after 2-flop synchronizer; all decisions use col_sync.
- Dwell counter width: clog2(SCAN_DIV). Debounce counter width: clog2(DEBOUNCE_CNT+1). Counters saturate, never wrap.
- SCAN:
  - Dwell counter increments every cycle.
  - On the cycle dwell==SCAN_DIV-1, col_sync is sampled.
  - Exactly one bit set: capture cand_row=row_drive and cand_col=col_sync, clear the debounce counter, go to DEBOUNCE. row_drive is frozen.
  - Zero bits or more than one bit set: rotate row_drive left (1000 wraps to 0001), clear dwell, stay in SCAN.
- DEBOUNCE:
  - row_drive is held. On each cycle with col_sync==cand_col, the counter increments.
  - Any mismatch: go to SCAN, rotate row_drive, clear dwell.
  - When the counter reaches DEBOUNCE_CNT: next cycle row=cand_row, col=cand_col, key_valid=1, key_press=1 for exactly one cycle; go to HELD.
  - Key press latency from first sampled dwell end = DEBOUNCE_CNT+1 cycles.
- HELD:
  - row_drive is held; outputs are stable.
  - Stays in HELD while the cand_col bit of col_sync is set. Extra simultaneous keys in the same row are ignored.
  - When the cand_col bit clears: clear the counter, go to RELEASE.
- RELEASE:
  - The counter increments each cycle the cand_col bit is clear.
  - If the bit reappears: clear the counter, return to HELD. No pulse; key_valid stays 1.
  - When the counter reaches DEBOUNCE_CNT: next cycle row=0, col=0, key_valid=0, key_release=1 for one cycle. Go to SCAN with row_drive rotated and dwell cleared.
- key_press and key_release never assert in the same cycle. At most one key_press per key_release.
- Reset mid-operation, in any state: outputs and state return to reset values on the next edge. No release pulse is generated.
- col_in changes during a row's dwell before the sample cycle have no effect; only the dwell-end sample matters.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset, then col_in=0 for 20 cycles -> row_drive cycles 0001,0010,0100,1000,0001 at 4 cycles each; key_valid=0; row=col=0.
- Hold col_in=0100 only while row_drive=0010, steady -> key_press single pulse, key_valid=1, row=0010, col=0100, row_drive frozen at 0010. Decoder value=6.
- Release the key for 5 cycles -> exactly one key_release pulse 4 cycles after the first 0 sample reaches col_sync; row=col=0; scanning resumes at row_drive=0100.
- Bounce on press (0100,0,0100 alternating each cycle) -> no key_press; scanner rotates to the next row after the mismatch.
- While held, drop col for 1 cycle and then restore -> no key_release, key_valid stays 1, no second key_press.
- Two columns set (0011) at dwell end -> ignored, row_drive rotates. Assert rst_n=0 while HELD -> next edge gives key_valid=0, row_drive=0001, no pulses.
